lcd_cmd_sequencer: RTL

LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

---
 rtl/lcd_cmd_sequencer_if.sv | 19 +
 rtl/lcd_cmd_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer_if.sv
// Command handshake between an upstream producer and the LCD command sequencer.
// The producer (master) offers a 9-bit {RS, code} word; the sequencer (slave) signals readiness.
interface lcd_cmd_sequencer_if;
    logic       cmd_valid;
    logic [8:0] cmd_data;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// HD44780-style 8-bit write-only LCD sequencer: power-up delay, fixed init ROM,
// then one strobed write per accepted command with RS/DATA held until the next load.
module lcd_cmd_sequencer #(
    parameter int unsigned T_POWERUP_CYC = 2000000,
    parameter int unsigned T_SETUP_CYC   = 2,
    parameter int unsigned T_EN_CYC      = 12,
    parameter int unsigned T_SHORT_CYC   = 2000,
    parameter int unsigned T_LONG_CYC    = 80000
) (
    input  logic                clk,
    input  logic                rst,
    lcd_cmd_sequencer_if.slave  cmd_if,
    output logic                init_done,
    output logic                busy,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic                lcd_en,
    output logic [7:0]          lcd_data
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_T =
        max2(max2(max2(T_POWERUP_CYC, T_SETUP_CYC), max2(T_EN_CYC, T_SHORT_CYC)), T_LONG_CYC);
    localparam int CNT_BITS = $clog2(MAX_T + 1);
    localparam int CNT_W    = (CNT_BITS > 24) ? CNT_BITS : 24;

    localparam logic [CNT_W-1:0] LOAD_POWERUP = CNT_W'(T_POWERUP_CYC);
    localparam logic [CNT_W-1:0] LOAD_SETUP   = CNT_W'(T_SETUP_CYC);
    localparam logic [CNT_W-1:0] LOAD_EN      = CNT_W'(T_EN_CYC);
    localparam logic [CNT_W-1:0] LOAD_SHORT   = CNT_W'(T_SHORT_CYC);
    localparam logic [CNT_W-1:0] LOAD_LONG    = CNT_W'(T_LONG_CYC);

    localparam logic [8:0] CMD_FUNCTION_SET  = 9'h038;
    localparam logic [8:0] CMD_DISPLAY_ON    = 9'h00C;
    localparam logic [8:0] CMD_CLEAR_DISPLAY = 9'h001;
    localparam logic [8:0] CMD_ENTRY_RIGHT   = 9'h006;
    localparam int         INIT_LEN          = 4;

    localparam logic [9*INIT_LEN-1:0] INIT_SEQ =
        {CMD_ENTRY_RIGHT, CMD_CLEAR_DISPLAY, CMD_DISPLAY_ON, CMD_FUNCTION_SET};

    typedef enum logic [2:0] {
        ST_POWERUP   = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_SETUP     = 3'd2,
        ST_PULSE     = 3'd3,
        ST_WAIT      = 3'd4,
        ST_IDLE      = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       bus_q, bus_d;
    logic [2:0]       init_idx_q, init_idx_d;
    logic             init_done_q, init_done_d;
    logic             en_q;
    logic             ready_q;
    logic             busy_q;

    logic [8:0] init_rom [INIT_LEN];

    for (genvar gi = 0; gi < INIT_LEN; gi++) begin : g_init_rom
        assign init_rom[gi] = INIT_SEQ[gi*9 +: 9];
    end

    logic cnt_last;
    logic long_wait;
    logic take_cmd;

    // A zero or one count both finish a phase, so a zero parameter never wraps the counter.
    assign cnt_last  = (cnt_q <= CNT_W'(1));
    // Clear (0x01) and return-home (0x02/0x03) need the long settle time.
    assign long_wait = ~bus_q[8] && (bus_q[7:2] == 6'd0) && (bus_q[1:0] != 2'd0);
    assign take_cmd  = cmd_if.cmd_valid && ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_d       = bus_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;

        case (state_q)
            ST_POWERUP: begin
                if (cnt_last) begin
                    state_d = ST_INIT_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_INIT_LOAD: begin
                bus_d      = init_rom[init_idx_q[1:0]];
                init_idx_d = init_idx_q + 3'd1;
                cnt_d      = LOAD_SETUP;
                state_d    = ST_SETUP;
            end

            ST_SETUP: begin
                if (cnt_last) begin
                    cnt_d   = LOAD_EN;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_PULSE: begin
                if (cnt_last) begin
                    cnt_d   = long_wait ? LOAD_LONG : LOAD_SHORT;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_WAIT: begin
                if (!cnt_last) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (init_done_q) begin
                    state_d = ST_IDLE;
                end else if (init_idx_q == 3'(INIT_LEN)) begin
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_INIT_LOAD;
                end
            end

            ST_IDLE: begin
                if (take_cmd) begin
                    bus_d   = cmd_if.cmd_data;
                    cnt_d   = LOAD_SETUP;
                    state_d = ST_SETUP;
                end
            end

            default: begin
                cnt_d   = LOAD_POWERUP;
                state_d = ST_POWERUP;
            end
        endcase
    end

    // Strobe and handshake outputs are registered from the next state so they are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_POWERUP;
            cnt_q       <= LOAD_POWERUP;
            bus_q       <= 9'h000;
            init_idx_q  <= 3'd0;
            init_done_q <= 1'b0;
            en_q        <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_q       <= bus_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            en_q        <= (state_d == ST_PULSE);
            ready_q     <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign cmd_if.cmd_ready = ready_q;
    assign init_done        = init_done_q;
    assign busy             = busy_q;
    assign lcd_rs           = bus_q[8];
    assign lcd_data         = bus_q[7:0];
    assign lcd_en           = en_q;
    assign lcd_rw           = 1'b0;

endmodule
